// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the display scan controller.
//   scan_state_t : scan FSM states
//   ANODE_OFF    : inactive anode level (common-anode, active-low drive)
//   IDX_W()      : width of a digit index for n digits (minimum 1)
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam logic ANODE_OFF = 1'b1;

  function automatic int IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of N_DIGITS common-anode digits that
// share one seven-segment decoder. A shadow buffer catches loads; it moves to
// the active buffer only at a frame boundary (or when scanning starts), so a
// frame never mixes old and new data. Each digit is preceded by a blanking
// gap with all anodes off while the registered nibble/dp settle.
//
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero suppression).
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   enable_i      1 = scan, 0 = display dark
//   load_i        strobe, captures value_i/dp_i into shadow buffer
//   value_i       packed nibbles, digit 0 in bits [3:0]
//   dp_i          decimal-point request per digit, 1 = on
//   digit_o       nibble to decoder
//   an_o          active-low anodes (one low, or all high)
//   dp_o          active-low decimal point
//   idx_o         currently selected digit
//   frame_done_o  pulse in the last SHOW cycle of the last digit
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          load_i,
  input  logic [4*N_DIGITS-1:0]         value_i,
  input  logic [N_DIGITS-1:0]           dp_i,
  output logic [3:0]                    digit_o,
  output logic [N_DIGITS-1:0]           an_o,
  output logic                          dp_o,
  output logic [IDX_W(N_DIGITS)-1:0]    idx_o,
  output logic                          frame_done_o
);

  localparam int IW   = IDX_W(N_DIGITS);
  localparam int CMAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CW   = (CMAX <= 2) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;

  logic [N_DIGITS-1:0][3:0] shadow, active, active_nxt;
  logic [N_DIGITS-1:0]      shadow_dp, active_dp, active_dp_nxt;
  logic                     pending, xfer, blank_entry, lz_dark;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    blank_entry  = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_nxt   = BLANK;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          blank_entry = 1'b1;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt   = BLANK;
          cnt_nxt     = '0;
          blank_entry = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt      = '0;
            frame_done_o = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable_i) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      idx_nxt     = '0;
      blank_entry = 1'b0;
    end
  end

  // Boundary transfer uses the old shadow; a coincident load lands after it.
  assign xfer          = pending && (frame_done_o || (state == IDLE && enable_i));
  assign active_nxt    = xfer ? shadow    : active;
  assign active_dp_nxt = xfer ? shadow_dp : active_dp;

`ifdef SEG_LZ_BLANK_EN
  // upz[i]: nibbles i..N_DIGITS-1 of the active buffer are all zero
  logic [N_DIGITS-1:0] upz;
  always_comb begin
    upz = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      upz[i] = 1'b1;
      for (int j = i; j < N_DIGITS; j++)
        if (active[j] != 4'h0) upz[i] = 1'b0;
    end
  end
  assign lz_dark = (idx != '0) && upz[idx];
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    an_o = {N_DIGITS{ANODE_OFF}};
    if (state == SHOW && !lz_dark) an_o[idx] = ~ANODE_OFF;
  end

  assign idx_o = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      active    <= '0;
      active_dp <= '0;
      pending   <= 1'b0;
      digit_o   <= 4'h0;
      dp_o      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      active    <= active_nxt;
      active_dp <= active_dp_nxt;
      if (load_i) begin
        shadow    <= value_i;
        shadow_dp <= dp_i;
        pending   <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      // Decoder inputs change only while all anodes are off.
      if (blank_entry) begin
        digit_o <= active_nxt[idx_nxt];
        dp_o    <= ~active_dp_nxt[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with N_DIGITS=4,
// TICK_DIV=8, BLANK_CYC=2. Per digit: 2 dark cycles then 8 lit cycles,
// frame = 40 cycles. Sample k is taken 1 ns after the k-th edge following
// the enable; p = (k-1) % 40 is the position inside the frame.
module tb_seg_scan_ctrl;
  localparam int N = 4;
  localparam int T = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable_i = 1'b0;
  logic         load_i = 1'b0;
  logic [15:0]  value_i = '0;
  logic [3:0]   dp_i = '0;
  logic [3:0]   digit_o;
  logic [3:0]   an_o;
  logic         dp_o;
  logic [1:0]   idx_o;
  logic         frame_done_o;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(T), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .load_i(load_i),
    .value_i(value_i), .dp_i(dp_i), .digit_o(digit_o), .an_o(an_o),
    .dp_o(dp_o), .idx_o(idx_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ($countones(~an_o) > 1) begin
        miscompares++;
        $display("FAIL onehot_an t=%0t an_o=%b (at most one low)", $time, an_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected anodes at frame position p; lit marks digits allowed to light
  function automatic logic [3:0] exp_an(input int p, input logic [3:0] lit);
    int d;
    int w;
    d = (p / (B + T)) % N;
    w = p % (B + T);
    exp_an = 4'hF;
    if (w >= B && lit[d]) exp_an[d] = 1'b0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; enable_i = 1'b0; load_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    value_i = v; dp_i = dp; load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_i = 1'b1;
    tick(); tick();
    vectors++;
    if (an_o !== 4'hF || digit_o !== 4'h0 || dp_o !== 1'b1 || idx_o !== 2'd0 || frame_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset an=%b digit=%h dp=%b idx=%0d fd=%b, want 1111 0 1 0 0",
               an_o, digit_o, dp_o, idx_o, frame_done_o);
    end
    enable_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [15:0] v;
    logic [3:0]  dp;
    int p;
    int d;
    v = 16'h1A3F; dp = 4'b0100;
    do_reset();
    load(v, dp);
    enable_i = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      p = (k - 1) % 40;
      d = p / 10;
      vectors++;
      if (an_o !== exp_an(p, 4'hF) || digit_o !== v[d*4 +: 4] || dp_o !== ~dp[d] ||
          idx_o !== 2'(d) || frame_done_o !== (p == 39)) begin
        miscompares++;
        $display("FAIL scan k=%0d an=%b digit=%h dp=%b idx=%0d fd=%b, want %b %h %b %0d %b",
                 k, an_o, digit_o, dp_o, idx_o, frame_done_o,
                 exp_an(p, 4'hF), v[d*4 +: 4], ~dp[d], d, (p == 39));
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_midframe();
    logic [15:0] v;
    int p;
    int d;
    do_reset();
    load(16'h1A3F, 4'b0000);
    enable_i = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 16) load_i = 1'b0;
      p = (k - 1) % 40;
      d = p / 10;
      v = (k <= 40) ? 16'h1A3F : 16'h1234;
      vectors++;
      if (an_o !== exp_an(p, 4'hF) || digit_o !== v[d*4 +: 4] || dp_o !== 1'b1) begin
        miscompares++;
        $display("FAIL midframe k=%0d an=%b digit=%h dp=%b, want %b %h 1",
                 k, an_o, digit_o, dp_o, exp_an(p, 4'hF), v[d*4 +: 4]);
      end
      if (k == 15) begin
        value_i = 16'h1234; load_i = 1'b1;
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_disable();
    do_reset();
    load(16'hBEEF, 4'b0001);
    enable_i = 1'b1;
    for (int k = 1; k <= 25; k++) tick();
    vectors++;
    if (an_o !== 4'b1011 || idx_o !== 2'd2) begin
      miscompares++;
      $display("FAIL disable_pre an=%b idx=%0d, want 1011 2", an_o, idx_o);
    end
    enable_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (an_o !== 4'hF || idx_o !== 2'd0 || frame_done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL disable_dark c=%0d an=%b idx=%0d fd=%b, want 1111 0 0", k, an_o, idx_o, frame_done_o);
      end
    end
    enable_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (an_o !== ((k <= B) ? 4'hF : 4'b1110) || idx_o !== 2'd0 || digit_o !== 4'hF || dp_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reenable k=%0d an=%b idx=%0d digit=%h dp=%b, want %b 0 f 0",
                 k, an_o, idx_o, digit_o, dp_o, (k <= B) ? 4'hF : 4'b1110);
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    load(16'h5678, 4'b1111);
    enable_i = 1'b1;
    for (int k = 1; k <= 13; k++) tick();
    vectors++;
    if (an_o !== 4'b1101 || digit_o !== 4'h7 || dp_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pre an=%b digit=%h dp=%b, want 1101 7 0", an_o, digit_o, dp_o);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (an_o !== 4'hF || digit_o !== 4'h0 || dp_o !== 1'b1 || idx_o !== 2'd0 || frame_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid an=%b digit=%h dp=%b idx=%0d fd=%b, want 1111 0 1 0 0",
               an_o, digit_o, dp_o, idx_o, frame_done_o);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      p = k - 1;
      vectors++;
      if (an_o !== exp_an(p, 4'hF) || digit_o !== 4'h0 || dp_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_cleared k=%0d an=%b digit=%h dp=%b, want %b 0 1",
                 k, an_o, digit_o, dp_o, exp_an(p, 4'hF));
      end
    end
    enable_i = 1'b0;
  endtask

`ifdef SEG_LZ_BLANK_EN
  task automatic test_lz();
    logic [15:0] v;
    logic [3:0]  lit;
    int d;
    for (int c = 0; c < 2; c++) begin
      v   = (c == 0) ? 16'h0050 : 16'h0000;
      lit = (c == 0) ? 4'b0011  : 4'b0001;
      do_reset();
      load(v, 4'b0000);
      enable_i = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        tick();
        d = (k - 1) / 10;
        vectors++;
        if (an_o !== exp_an(k - 1, lit) || digit_o !== v[d*4 +: 4]) begin
          miscompares++;
          $display("FAIL lz v=%h k=%0d an=%b digit=%h, want %b %h",
                   v, k, an_o, digit_o, exp_an(k - 1, lit), v[d*4 +: 4]);
        end
      end
      enable_i = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_disable();
    test_reset_mid();
`ifdef SEG_LZ_BLANK_EN
    test_lz();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
